fifo_sync_rd_stream: RTL

- Reader for the team's synchronous FIFO in read-request mode (LOOKAHEAD=0, 1-cycle registered read latency).
- Issues FIFO read requests and buffers the returned words in a 2-entry output buffer.
- Presents the words as a valid/ready stream at 1 word/clock sustained, with backpressure.
- Sits between the FIFO read port and any downstream stream consumer.

---
 rtl/fifo_rd_pkg.sv | 8 +
 rtl/fifo_rd_skid2.sv | 81 ++++++++
 rtl/fifo_sync_rd_stream.sv | 92 +++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-stream adapter: buffer depth, buffer FSM states, occupancy.
package fifo_rd_pkg;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry head/tail output buffer; push lands in head when free, else tail. Output from head flop.
// No internal backpressure: the caller's credit rule guarantees no push while full.
module fifo_rd_skid2
  import fifo_rd_pkg::*;
#(
  parameter int G_W = 72
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic           i_sclr,
  input  logic           i_push,
  input  logic [G_W-1:0] i_push_data,
  input  logic           i_pop,
  output logic           o_valid,
  output logic [G_W-1:0] o_data,
  output logic [1:0]     o_occ
);

  buf_state_t     state_q, state_d;
  logic [G_W-1:0] head_q, head_d;
  logic [G_W-1:0] tail_q, tail_d;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (i_push) begin
          state_d = ONE;
          head_d  = i_push_data;
        end
      end
      ONE: begin
        if (i_push && !i_pop) begin
          state_d = TWO;
          tail_d  = i_push_data;
        end else if (i_pop && !i_push) begin
          state_d = EMPTY;
        end else if (i_push && i_pop) begin
          head_d = i_push_data;
        end
      end
      TWO: begin
        if (i_pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Clear wins over any push/pop in the same cycle.
    if (i_sclr) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  assign o_valid = (state_q != EMPTY);
  assign o_data  = head_q;
  assign o_occ   = occ_t'(state_q);

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_arst_n)
    !(i_push && state_q == TWO));
`endif

endmodule

// File: rtl/fifo_sync_rd_stream.sv
// FIFO read-request (1-cycle latency) to valid/ready stream, 1 word/clk; first word 2 clks after rena.
// Credit-limited to 2 words buffered+in flight under backpressure. Stats counters built only with FIFO_RD_STATS_EN.
module fifo_sync_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int G_W    = 72,
  parameter int G_CNTW = 32
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_sclr,
  output logic              o_fifo_rena,
  input  logic [G_W-1:0]    i_fifo_rdat,
  input  logic              i_fifo_empt,
  output logic              o_tvalid,
  output logic [G_W-1:0]    o_tdata,
  input  logic              i_tready,
  output logic [G_CNTW-1:0] o_stat_words,
  output logic [G_CNTW-1:0] o_stat_stall
);

  logic       inflight_q, inflight_d;
  logic       pop;
  logic       push;
  logic [1:0] occ;
  logic [2:0] credit_sum;

  assign pop  = o_tvalid & i_tready;
  assign push = inflight_q & ~i_sclr;

  // Words committed downstream of the FIFO after this cycle's pop; must stay below buffer depth.
  assign credit_sum  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign o_fifo_rena = ~i_fifo_empt & ~i_sclr & (credit_sum < 3'(BUF_DEPTH));
  assign inflight_d  = o_fifo_rena;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) inflight_q <= 1'b0;
    else           inflight_q <= inflight_d;
  end

  fifo_rd_skid2 #(.G_W(G_W)) u_skid (
    .i_clk       (i_clk),
    .i_arst_n    (i_arst_n),
    .i_sclr      (i_sclr),
    .i_push      (push),
    .i_push_data (i_fifo_rdat),
    .i_pop       (pop),
    .o_valid     (o_tvalid),
    .o_data      (o_tdata),
    .o_occ       (occ)
  );

`ifdef FIFO_RD_STATS_EN
  logic [G_CNTW-1:0] stat_words_q, stat_words_d;
  logic [G_CNTW-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    if (pop && !(&stat_words_q))
      stat_words_d = stat_words_q + G_CNTW'(1);
    if (o_tvalid && !i_tready && !(&stat_stall_q))
      stat_stall_d = stat_stall_q + G_CNTW'(1);
    if (i_sclr) begin
      stat_words_d = '0;
      stat_stall_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign o_stat_words = stat_words_q;
  assign o_stat_stall = stat_stall_q;
`else
  assign o_stat_words = '0;
  assign o_stat_stall = '0;
`endif

`ifndef SYNTHESIS
  a_tdata_stable: assert property (@(posedge i_clk) disable iff (!i_arst_n || i_sclr)
    (o_tvalid && !i_tready) |=> $stable(o_tdata));
`endif

endmodule
